// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard -- D-stage hazard unit built on a Tuse/Tnew scoreboard.
//
// Tracks in-flight GPR writers for STAGES stages after D (1 = E, 2 = M,
// 3 = W). From them it derives the D-stage stall and the D-stage forward
// selects. An optional multiply/divide busy counter stalls HI/LO users; it
// is compiled in only when the macro HAZARD_MD_EN is defined. Without it,
// md_busy is tied low and the d_md_* inputs are ignored.
//
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   d_valid                  D holds a real instruction
//   d_rs, d_rt               D source registers
//   d_tuse_rs, d_tuse_rt     cycles until operand needed (all-ones = unused)
//   d_wr, d_dst, d_tnew      D writer info (Tnew on entry to E)
//   d_md_start, d_md_div     mult/div issue; 1 = divide
//   d_md_use                 mfhi/mflo/mthi/mtlo
//   stall                    hold PC and F/D, bubble into E
//   fwd_rs_sel, fwd_rt_sel   0 = GRF, k = stage k
//   md_busy                  multiply/divide unit occupied

// Per-source lookup: finds the youngest in-flight writer of src_i and
// decides stall / forward for that operand.
module hazard_src_chk #(
  parameter int STAGES = 3,
  parameter int RW     = 5,
  parameter int TW     = 2,
  parameter int SW     = 2
) (
  input  logic [RW-1:0]              src_i,
  input  logic [TW-1:0]              tuse_i,
  input  logic [STAGES-1:0]          vld_i,
  input  logic [STAGES-1:0][RW-1:0]  dst_i,
  input  logic [STAGES-1:0][TW-1:0]  tnew_i,
  output logic                       stall_o,
  output logic [SW-1:0]              sel_o
);
  logic          used;
  logic          hit;
  logic [SW-1:0] hit_k;
  logic [TW-1:0] hit_tnew;

  assign used = (src_i != '0) && (tuse_i != '1);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit      = 1'b0;
    hit_k    = '0;
    hit_tnew = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      if (vld_i[k] && (dst_i[k] == src_i)) begin
        hit      = 1'b1;
        hit_k    = SW'(k+1);
        hit_tnew = tnew_i[k];
      end
    end
  end

  assign stall_o = used && hit && (hit_tnew > tuse_i);
  // A pending writer with 0 < tnew <= tuse is picked up by the downstream
  // forward muxes, so D reads the GRF path here.
  assign sel_o   = (used && hit && (hit_tnew == '0)) ? hit_k : '0;
endmodule

module hazard_scoreboard #(
  parameter int STAGES   = 3,
  parameter int RW       = 5,
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         d_valid,
  input  logic [RW-1:0]                d_rs,
  input  logic [RW-1:0]                d_rt,
  input  logic [TW-1:0]                d_tuse_rs,
  input  logic [TW-1:0]                d_tuse_rt,
  input  logic                         d_wr,
  input  logic [RW-1:0]                d_dst,
  input  logic [TW-1:0]                d_tnew,
  input  logic                         d_md_start,
  input  logic                         d_md_div,
  input  logic                         d_md_use,
  output logic                         stall,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rs_sel,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rt_sel,
  output logic                         md_busy
);
  localparam int SW = $clog2(STAGES+1);

  // Scoreboard: index k holds stage k+1. sb_vld_q doubles as the valid pipe.
  logic [STAGES-1:0]         sb_vld_q,  sb_vld_d;
  logic [STAGES-1:0][RW-1:0] sb_dst_q,  sb_dst_d;
  logic [STAGES-1:0][TW-1:0] sb_tnew_q, sb_tnew_d;

  logic [1:0][RW-1:0] src;
  logic [1:0][TW-1:0] tuse;
  logic [1:0]         op_stall;
  logic [1:0][SW-1:0] sel;
  logic               md_stall;

  assign src  = {d_rt, d_rs};
  assign tuse = {d_tuse_rt, d_tuse_rs};

  for (genvar s = 0; s < 2; s++) begin : g_src
    hazard_src_chk #(
      .STAGES(STAGES), .RW(RW), .TW(TW), .SW(SW)
    ) u_chk (
      .src_i   (src[s]),
      .tuse_i  (tuse[s]),
      .vld_i   (sb_vld_q),
      .dst_i   (sb_dst_q),
      .tnew_i  (sb_tnew_q),
      .stall_o (op_stall[s]),
      .sel_o   (sel[s])
    );
  end

  assign fwd_rs_sel = sel[0];
  assign fwd_rt_sel = sel[1];
  assign stall      = d_valid && ((|op_stall) || md_stall);

  // Entries advance every cycle; a stall only turns entry 1 into a bubble.
  always_comb begin
    sb_vld_d  = '0;
    sb_dst_d  = '0;
    sb_tnew_d = '0;
    if (d_valid && !stall) begin
      sb_vld_d[0]  = d_wr && (d_dst != '0);
      sb_dst_d[0]  = d_dst;
      sb_tnew_d[0] = d_tnew;
    end
    for (int k = 1; k < STAGES; k++) begin
      sb_vld_d[k]  = sb_vld_q[k-1];
      sb_dst_d[k]  = sb_dst_q[k-1];
      sb_tnew_d[k] = (sb_tnew_q[k-1] != '0) ? sb_tnew_q[k-1] - 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sb_vld_q  <= '0;
      sb_dst_q  <= '0;
      sb_tnew_q <= '0;
    end else begin
      sb_vld_q  <= sb_vld_d;
      sb_dst_q  <= sb_dst_d;
      sb_tnew_q <= sb_tnew_d;
    end
  end

`ifdef HAZARD_MD_EN
  localparam int CW = $clog2(DIV_CYC+1);
  logic [CW-1:0] md_cnt_q, md_cnt_d;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (d_valid && d_md_start && !stall)
      md_cnt_d = d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) md_cnt_q <= '0;
    else         md_cnt_q <= md_cnt_d;
  end

  assign md_busy  = (md_cnt_q != '0);
  // A new mult/div also waits, so a start at count 1 loads on the next issue.
  assign md_stall = d_valid && (d_md_start || d_md_use) && md_busy;
`else
  logic md_unused;
  assign md_unused = ^{d_md_start, d_md_div, d_md_use};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  localparam int STAGES = 3;
  localparam int RW     = 5;
  localparam int TW     = 2;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int SW     = $clog2(STAGES+1);

  logic          clk = 1'b0;
  logic          resetn;
  logic          d_valid, d_wr, d_md_start, d_md_div, d_md_use;
  logic [RW-1:0] d_rs, d_rt, d_dst;
  logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic          stall, md_busy;
  logic [SW-1:0] fwd_rs_sel, fwd_rt_sel;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .STAGES(STAGES), .RW(RW), .TW(TW), .MULT_CYC(MULT_N), .DIV_CYC(DIV_N)
  ) dut (
    .clk(clk), .resetn(resetn), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wr(d_wr), .d_dst(d_dst), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .md_busy(md_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference model: remembers each issued writer and its issue cycle; its
  // stage and remaining Tnew follow from its age.
  typedef struct { int dst; int tnew; int icyc; } wr_t;
  wr_t wq[$];
  int  cyc    = 0;
  int  md_end = -1;

  task automatic src_eval(input int s, input int tu, output int st, output int sel);
    int best = 99;
    int rem  = 0;
    foreach (wq[i]) begin
      int age = cyc - wq[i].icyc;
      if (age >= 1 && age <= STAGES && wq[i].dst == s && age < best) begin
        best = age;
        rem  = wq[i].tnew - (age - 1);
        if (rem < 0) rem = 0;
      end
    end
    st = 0; sel = 0;
    if (s != 0 && tu != 3 && best != 99) begin
      st  = (rem > tu) ? 1 : 0;
      sel = (rem == 0) ? best : 0;
    end
  endtask

  task automatic model_eval(output int es, output int ers, output int ert, output int eb);
    int s1, s2, md_st;
    src_eval(int'(d_rs), int'(d_tuse_rs), s1, ers);
    src_eval(int'(d_rt), int'(d_tuse_rt), s2, ert);
    eb = 0; md_st = 0;
`ifdef HAZARD_MD_EN
    eb    = (cyc <= md_end) ? 1 : 0;
    md_st = (d_valid && (d_md_start || d_md_use) && eb != 0) ? 1 : 0;
`endif
    es = (d_valid && (s1 != 0 || s2 != 0 || md_st != 0)) ? 1 : 0;
  endtask

  task automatic model_commit(input int es);
    if (!resetn) begin
      wq.delete();
      md_end = -1;
    end else if (d_valid && es == 0) begin
      if (d_wr && d_dst != 0) wq.push_back('{int'(d_dst), int'(d_tnew), cyc});
`ifdef HAZARD_MD_EN
      if (d_md_start) md_end = cyc + (d_md_div ? DIV_N : MULT_N);
`endif
    end
    cyc++;
    while (wq.size() > 0 && cyc - wq[0].icyc > STAGES) void'(wq.pop_front());
  endtask

  task automatic set(input bit v, input int rs, input int trs, input int rt, input int trt,
                     input bit wr, input int dst, input int tn,
                     input bit mds, input bit mdd, input bit mdu);
    d_valid = v; d_rs = RW'(rs); d_tuse_rs = TW'(trs); d_rt = RW'(rt); d_tuse_rt = TW'(trt);
    d_wr = wr; d_dst = RW'(dst); d_tnew = TW'(tn);
    d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
  endtask

  task automatic nop();
    set(1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
  endtask

  // One cycle: inputs already applied after negedge; check, then clock.
  task automatic step(input string nm, input bit chk, input bit use_model,
                      input int xs, input int xrs, input int xrt, input int xb);
    int ms, mrs, mrt, mb;
    #1;
    model_eval(ms, mrs, mrt, mb);
    if (use_model) begin xs = ms; xrs = mrs; xrt = mrt; xb = mb; end
    if (chk) begin
      chk1({nm, ".stall"}, int'(stall), xs);
      chk1({nm, ".fwd_rs"}, int'(fwd_rs_sel), xrs);
      chk1({nm, ".fwd_rt"}, int'(fwd_rt_sel), xrt);
      chk1({nm, ".md_busy"}, int'(md_busy), xb);
    end
    @(posedge clk);
    model_commit(ms);
    @(negedge clk);
  endtask

  typedef struct {
    string nm; bit v; int rs, trs, rt, trt; bit wr; int dst, tn; int es, ers, ert;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(string nm, bit v, int rs, int trs, int rt, int trt,
                              bit wr, int dst, int tn, int es, int ers, int ert);
    vec_t r;
    r.nm = nm; r.v = v; r.rs = rs; r.trs = trs; r.rt = rt; r.trt = trt;
    r.wr = wr; r.dst = dst; r.tn = tn; r.es = es; r.ers = ers; r.ert = ert;
    return r;
  endfunction

  function automatic vec_t vnop();
    return mk("nop", 1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    // lw $2 then add $4,$2,$3: one stall, then GRF path
    tbl.push_back(mk("lw2",      1, 29, 1, 0, 3, 1, 2, 2, 0, 0, 0));
    tbl.push_back(mk("add_stl",  1,  2, 1, 3, 1, 1, 4, 1, 1, 0, 0));
    tbl.push_back(mk("add_go",   1,  2, 1, 3, 1, 1, 4, 1, 0, 0, 0));
    repeat (3) tbl.push_back(vnop());
    // addu $3 then beq $3,$0: one stall then forward from M
    tbl.push_back(mk("addu3",    1,  1, 1, 2, 1, 1, 3, 1, 0, 0, 0));
    tbl.push_back(mk("beq_stl",  1,  3, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("beq_fwdM", 1,  3, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    repeat (3) tbl.push_back(vnop());
    // writer to $0 never hazards
    tbl.push_back(mk("wr_r0",    1,  0, 3, 0, 3, 1, 0, 2, 0, 0, 0));
    tbl.push_back(mk("rd_r0",    1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) tbl.push_back(vnop());
    // ori $5, lui $5, nop, beq $5,$5: younger (lui in M) wins
    tbl.push_back(mk("ori5",     1,  0, 3, 0, 3, 1, 5, 1, 0, 0, 0));
    tbl.push_back(mk("lui5",     1,  0, 3, 0, 3, 1, 5, 1, 0, 0, 0));
    tbl.push_back(vnop());
    tbl.push_back(mk("beq5",     1,  5, 0, 5, 0, 0, 0, 0, 0, 2, 2));
    repeat (3) tbl.push_back(vnop());
    // both operands hazardous on the same load
    tbl.push_back(mk("lw6",      1,  0, 3, 0, 3, 1, 6, 2, 0, 0, 0));
    tbl.push_back(mk("both_stl", 1,  6, 1, 6, 1, 1, 9, 1, 1, 0, 0));
    tbl.push_back(mk("both_go",  1,  6, 1, 6, 1, 0, 0, 0, 0, 0, 0));
    repeat (3) tbl.push_back(vnop());
    // younger lw $7 governs over older addu $7; ends with forward from W
    tbl.push_back(mk("addu7",    1,  0, 3, 0, 3, 1, 7, 1, 0, 0, 0));
    tbl.push_back(vnop());
    tbl.push_back(mk("lw7",      1,  0, 3, 0, 3, 1, 7, 2, 0, 0, 0));
    tbl.push_back(mk("rt7_stl1", 1,  0, 3, 7, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("rt7_stl2", 1,  0, 3, 7, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("rt7_fwdW", 1,  0, 3, 7, 0, 0, 0, 0, 0, 0, 3));
    repeat (3) tbl.push_back(vnop());
    // invalid D never stalls; the load keeps aging underneath
    tbl.push_back(mk("lw8",      1,  0, 3, 0, 3, 1, 8, 2, 0, 0, 0));
    tbl.push_back(mk("inv_rd8",  0,  8, 0, 0, 3, 1, 8, 0, 0, 0, 0));
    tbl.push_back(mk("rd8_stl",  1,  8, 0, 0, 3, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("rd8_fwdW", 1,  8, 0, 0, 3, 0, 0, 0, 0, 3, 0));
    repeat (3) tbl.push_back(vnop());
    // operand with all-ones Tuse is not read
    tbl.push_back(mk("lw9",      1,  0, 3, 0, 3, 1, 9, 2, 0, 0, 0));
    tbl.push_back(mk("unused9",  1,  9, 3, 9, 3, 0, 0, 0, 0, 0, 0));
    repeat (3) tbl.push_back(vnop());

    resetn = 1'b0;
    set(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step("rst0", 0, 0, 0, 0, 0, 0);
    step("rst1", 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    set(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 1);
    step("post_rst", 1, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      set(tbl[i].v, tbl[i].rs, tbl[i].trs, tbl[i].rt, tbl[i].trt,
          tbl[i].wr, tbl[i].dst, tbl[i].tn, 0, 0, 0);
      step(tbl[i].nm, 1, 0, tbl[i].es, tbl[i].ers, tbl[i].ert, 0);
    end

`ifdef HAZARD_MD_EN
    // mult then mfhi: 5 stall cycles
    set(1, 0, 3, 0, 3, 0, 0, 0, 1, 0, 0); step("mult", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < MULT_N; i++) begin
      set(1, 0, 3, 0, 3, 1, 10, 1, 0, 0, 1); step("mfhi_wait", 1, 0, 1, 0, 0, 1);
    end
    step("mfhi_go", 1, 0, 0, 0, 0, 0);
    nop(); step("nop_md", 1, 0, 0, 0, 0, 0);
    // div then mflo: 10 stall cycles
    set(1, 0, 3, 0, 3, 0, 0, 0, 1, 1, 0); step("div", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DIV_N; i++) begin
      set(1, 0, 3, 0, 3, 1, 11, 1, 0, 0, 1); step("mflo_wait", 1, 0, 1, 0, 0, 1);
    end
    step("mflo_go", 1, 0, 0, 0, 0, 0);
    // second mult arriving while the counter reads 1 waits one cycle
    set(1, 0, 3, 0, 3, 0, 0, 0, 1, 0, 0); step("mult_a", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < MULT_N-1; i++) begin
      nop(); step("md_run", 1, 0, 0, 0, 0, 1);
    end
    set(1, 0, 3, 0, 3, 0, 0, 0, 1, 0, 0); step("mult_b_stl", 1, 0, 1, 0, 0, 1);
    step("mult_b_go", 1, 0, 0, 0, 0, 0);
    nop(); step("mult_b_busy", 1, 0, 0, 0, 0, 1);
`else
    // without the MD unit, HI/LO traffic never stalls
    set(1, 0, 3, 0, 3, 0, 0, 0, 1, 1, 0); step("div_off", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      set(1, 0, 3, 0, 3, 1, 10, 1, 0, 0, 1); step("mfhi_off", 1, 0, 0, 0, 0, 0);
    end
`endif
    repeat (12) begin nop(); step("drain", 0, 0, 0, 0, 0, 0); end

    // reset with a div and a lw in flight clears everything
    set(1, 0, 3, 0, 3, 0, 0, 0, 1, 1, 0); step("rdiv", 1, 1, 0, 0, 0, 0);
    set(1, 0, 3, 0, 3, 1, 2, 2, 0, 0, 0); step("rlw", 1, 1, 0, 0, 0, 0);
    resetn = 1'b0;
    set(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0); step("rmid", 0, 1, 0, 0, 0, 0);
    resetn = 1'b1;
    set(1, 2, 0, 0, 3, 1, 4, 1, 0, 0, 1); step("after_rst", 1, 0, 0, 0, 0, 0);

    // random traffic checked against the model
    for (int i = 0; i < 800; i++) begin
      resetn = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      set($urandom_range(0, 9) < 8,
          $urandom_range(0, 7), $urandom_range(0, 3),
          $urandom_range(0, 7), $urandom_range(0, 3),
          $urandom_range(0, 1) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
          $urandom_range(0, 9) == 0, $urandom_range(0, 1) != 0,
          $urandom_range(0, 9) == 0);
      step("rnd", 1, 1, 0, 0, 0, 0);
    end
    resetn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
